// File: rtl/vx_cache_flush_ctrl.sv
// vx_cache_flush_ctrl
//   Flush sequencer for a cluster of NUM_CACHES cache units shared by NUM_INPUTS
//   core ports. A flush request locks out new core requests, waits until every
//   tracked read has returned, flushes the cache units one at a time in ascending
//   index order, and then presents a single completion response.
//
// Parameters
//   NUM_CACHES    cache units to flush
//   NUM_INPUTS    core ports whose outstanding reads are counted
//   PENDING_SIZE  maximum outstanding reads per port
//   ASSERT_EN     enables the simulation-only protocol checks
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   flush_req_valid / flush_req_ready  flush request handshake (ready only in IDLE)
//   flush_rsp_valid / flush_rsp_ready  flush completion handshake
//   core_req_fire / core_rsp_fire      per-port read request / response handshakes
//   core_req_lock                      tells the arbiter to hold core requests off
//   cache_flush_valid / _ready         one-hot flush command to the selected unit
//   cache_flush_done                   per-unit 1-cycle completion pulse
//   busy                               sequencer is not idle
module vx_cache_flush_ctrl #(
  parameter int NUM_CACHES   = 1,
  parameter int NUM_INPUTS   = 1,
  parameter int PENDING_SIZE = 16,
  parameter bit ASSERT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_req_valid,
  output logic                  flush_req_ready,
  output logic                  flush_rsp_valid,
  input  logic                  flush_rsp_ready,
  input  logic [NUM_INPUTS-1:0] core_req_fire,
  input  logic [NUM_INPUTS-1:0] core_rsp_fire,
  output logic                  core_req_lock,
  output logic [NUM_CACHES-1:0] cache_flush_valid,
  input  logic [NUM_CACHES-1:0] cache_flush_ready,
  input  logic [NUM_CACHES-1:0] cache_flush_done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(PENDING_SIZE + 1);
  localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PENDING_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CACHES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_INPUTS-1:0]  cnt_zero;
  logic                   all_drained;
  logic [NUM_CACHES-1:0]  sel_onehot;
  logic                   stray_done;

  // ---------------------------------------------------------------------------
  // Outstanding-read counters. They keep counting through a flush so that reads
  // accepted in the same cycle as the flush request are still waited for.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_pending
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        case ({core_req_fire[gi], core_rsp_fire[gi]})
          2'b10: if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
          2'b01: if (cnt_reg != '0)      cnt_next = cnt_reg - 1'b1;
          default: cnt_next = cnt_reg;  // idle, or request and response cancel out
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          if (ASSERT_EN) begin
            pending_overflow: assert (!(core_req_fire[gi] && !core_rsp_fire[gi] &&
                                        cnt_reg == CNT_MAX));
            pending_underflow: assert (!(!core_req_fire[gi] && core_rsp_fire[gi] &&
                                         cnt_reg == '0));
          end
        end
      end

      assign cnt_zero[gi] = (cnt_reg == '0);
    end
  endgenerate

  assign all_drained = &cnt_zero;
  assign sel_onehot  = NUM_CACHES'(1) << idx_reg;

  // ---------------------------------------------------------------------------
  // Sequencer state register. With a single cache unit the index is tied to 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= (NUM_CACHES > 1) ? idx_next : '0;
    end
  end

  // Next state and outputs; every output is a pure decode of the current state.
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    flush_req_ready   = 1'b0;
    flush_rsp_valid   = 1'b0;
    core_req_lock     = 1'b1;
    cache_flush_valid = '0;
    busy              = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        flush_req_ready = 1'b1;
        core_req_lock   = 1'b0;
        busy            = 1'b0;
        if (flush_req_valid) begin
          state_next = ST_DRAIN;
          idx_next   = '0;
        end
      end
      ST_DRAIN: begin
        // Registered counters: a response in this cycle is seen one cycle later.
        if (all_drained) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        cache_flush_valid = sel_onehot;
        if (|(cache_flush_ready & sel_onehot)) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Only the selected unit's completion pulse advances the sequence.
        if (|(cache_flush_done & sel_onehot)) begin
          if (idx_reg == IDX_LAST) begin
            state_next = ST_RESP;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_RESP: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A completion pulse that the sequencer cannot use points at a misbehaving unit.
  assign stray_done = ((state_reg == ST_ISSUE) && (|cache_flush_done)) ||
                      ((state_reg == ST_WAIT)  && (|(cache_flush_done & ~sel_onehot)));

  always_ff @(posedge clk) begin
    if (!reset && ASSERT_EN) begin
      stray_flush_done: assert (!stray_done);
    end
  end

endmodule
